// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite responder that executes single AXI4-Lite transactions as cycles on a
// synchronous single-port SRAM (1-cycle read latency), one transaction in flight.
module axi4_lite_sram_slave #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [BUS_WIDTH-1:0]         ar_addr,
    input  logic [2:0]                   ar_prot,
    input  logic                         aw_valid,
    output logic                         aw_ready,
    input  logic [BUS_WIDTH-1:0]         aw_addr,
    input  logic [2:0]                   aw_prot,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_resp,
    input  logic                         wd_valid,
    output logic                         wd_ready,
    input  logic [DATA_WIDTH-1:0]        wd_data,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic                         wr_breap,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]        sram_wdata,
    output logic [DATA_WIDTH/8-1:0]      sram_wmask,
    input  logic [DATA_WIDTH-1:0]        sram_rdata
);
    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int WORD_W = BUS_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [WORD_W-1:0] MEM_LIMIT = WORD_W'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, RD_MEM, RD_RESP, WR_MEM, WR_RESP} state_e;

    state_e                state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic                  last_grant_wr_q, last_grant_wr_d;
    logic [ADDR_W-1:0]     ar_word_q, ar_word_d;
    logic [ADDR_W-1:0]     aw_word_q, aw_word_d;
    logic                  rd_ok_q, rd_ok_d;
    logic                  wr_ok_q, wr_ok_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  rd_first_q, rd_first_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  aw_hs, w_hs, grant_wr;
    logic [DATA_WIDTH-1:0] rd_now;
    logic                  unused_bits;

    assign unused_bits = ^{ar_prot, aw_prot, ar_addr[1:0], aw_addr[1:0]};

    always_comb begin
        state_d         = state_q;
        aw_held_d       = aw_held_q;
        w_held_d        = w_held_q;
        last_grant_wr_d = last_grant_wr_q;
        ar_word_d       = ar_word_q;
        aw_word_d       = aw_word_q;
        rd_ok_d         = rd_ok_q;
        wr_ok_d         = wr_ok_q;
        w_data_d        = w_data_q;
        w_strb_d        = w_strb_q;
        rd_first_d      = rd_first_q;
        rd_data_d       = rd_data_q;
        ar_ready        = 1'b0;
        aw_ready        = 1'b0;
        wd_ready        = 1'b0;
        rd_valid        = 1'b0;
        rd_data         = '0;
        rd_resp         = 1'b0;
        wr_valid        = 1'b0;
        wr_breap        = 1'b0;
        sram_ce         = 1'b0;
        sram_we         = 1'b0;
        sram_addr       = '0;
        sram_wdata      = '0;
        sram_wmask      = '0;
        aw_hs           = 1'b0;
        w_hs            = 1'b0;
        grant_wr        = 1'b0;
        rd_now          = '0;

        if (!reset) begin
            // AW and W halves are collected independently, even while a read is in flight
            aw_ready = !aw_held_q;
            wd_ready = !w_held_q;
            aw_hs    = aw_valid && aw_ready;
            w_hs     = wd_valid && wd_ready;
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_word_d = aw_addr[ADDR_W+1:2];
                wr_ok_d   = aw_addr[BUS_WIDTH-1:2] < MEM_LIMIT;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = wd_data;
                w_strb_d = wstrb;
            end

            case (state_q)
                IDLE: begin
                    grant_wr = ar_valid && (aw_valid || aw_held_q || w_held_q) && !last_grant_wr_q;
                    ar_ready = !aw_held_q && !w_held_q && !grant_wr;
                    if (ar_valid && ar_ready) begin
                        ar_word_d       = ar_addr[ADDR_W+1:2];
                        rd_ok_d         = ar_addr[BUS_WIDTH-1:2] < MEM_LIMIT;
                        last_grant_wr_d = 1'b0;
                        state_d         = RD_MEM;
                    end else if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                        last_grant_wr_d = 1'b1;
                        state_d         = WR_MEM;
                    end
                end
                RD_MEM: begin
                    sram_ce    = rd_ok_q;
                    sram_addr  = rd_ok_q ? ar_word_q : '0;
                    rd_first_d = 1'b1;
                    state_d    = RD_RESP;
                end
                RD_RESP: begin
                    // SRAM output is only valid in the first response cycle; hold it afterwards
                    if (rd_first_q) rd_now = rd_ok_q ? sram_rdata : '0;
                    else            rd_now = rd_data_q;
                    rd_valid   = 1'b1;
                    rd_data    = rd_now;
                    rd_resp    = rd_ok_q;
                    rd_data_d  = rd_now;
                    rd_first_d = 1'b0;
                    if (rd_ready) state_d = IDLE;
                end
                WR_MEM: begin
                    sram_ce    = wr_ok_q;
                    sram_we    = wr_ok_q;
                    sram_addr  = wr_ok_q ? aw_word_q : '0;
                    sram_wdata = wr_ok_q ? w_data_q : '0;
                    sram_wmask = wr_ok_q ? w_strb_q : '0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    state_d    = WR_RESP;
                end
                WR_RESP: begin
                    wr_valid = 1'b1;
                    wr_breap = wr_ok_q;
                    if (wr_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q         <= IDLE;
            aw_held_q       <= 1'b0;
            w_held_q        <= 1'b0;
            last_grant_wr_q <= 1'b1;
            ar_word_q       <= '0;
            aw_word_q       <= '0;
            rd_ok_q         <= 1'b0;
            wr_ok_q         <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            rd_first_q      <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            aw_held_q       <= aw_held_d;
            w_held_q        <= w_held_d;
            last_grant_wr_q <= last_grant_wr_d;
            ar_word_q       <= ar_word_d;
            aw_word_q       <= aw_word_d;
            rd_ok_q         <= rd_ok_d;
            wr_ok_q         <= wr_ok_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            rd_first_q      <= rd_first_d;
            rd_data_q       <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Directed self-checking bench for axi4_lite_sram_slave with a behavioural SRAM
// that only presents valid read data in the cycle after a read strobe.
module tb_axi4_lite_sram_slave;
    localparam int MEM_WORDS = 1024;

    logic        aclk = 1'b0;
    logic        reset;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        rd_resp;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wstrb;
    logic        wr_valid, wr_ready, wr_breap;
    logic        sram_ce, sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_rdata;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 aclk = ~aclk;

    axi4_lite_sram_slave #(
        .BUS_WIDTH (32),
        .DATA_WIDTH(32),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .aclk      (aclk),
        .reset     (reset),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_prot   (ar_prot),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .aw_addr   (aw_addr),
        .aw_prot   (aw_prot),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_resp   (rd_resp),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wstrb     (wstrb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_breap  (wr_breap),
        .sram_ce   (sram_ce),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_wmask(sram_wmask),
        .sram_rdata(sram_rdata)
    );

    // Behavioural SRAM; read data outside the cycle after a read is poisoned
    logic [31:0] mem [MEM_WORDS];
    always @(posedge aclk) begin
        if (sram_ce && sram_we) begin
            for (int unsigned b = 0; b < 4; b++)
                if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        sram_rdata <= (sram_ce && !sram_we) ? mem[sram_addr] : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic ok);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int unsigned n = 0;
        logic [31:0] a;
        a = addr;
        aw_valid = 1'b1; aw_addr = addr;
        wd_valid = 1'b1; wd_data = data; wstrb = strb;
        wr_ready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge aclk);
            if (aw_valid && aw_ready) aw_done = 1'b1;
            if (wd_valid && wd_ready) w_done = 1'b1;
            step();
            if (aw_done) aw_valid = 1'b0;
            if (w_done)  wd_valid = 1'b0;
            n++;
        end
        aw_valid = 1'b0; wd_valid = 1'b0;
        check({tag, "_hs"}, {31'd0, aw_done && w_done}, 32'd1);
        @(negedge aclk);
        check({tag, "_ce"}, {31'd0, sram_ce}, {31'd0, ok});
        check({tag, "_we"}, {31'd0, sram_we}, {31'd0, ok});
        if (ok) begin
            check({tag, "_addr"}, {22'd0, sram_addr}, {22'd0, a[11:2]});
            check({tag, "_mask"}, {28'd0, sram_wmask}, {28'd0, strb});
        end
        step();
        @(negedge aclk);
        check({tag, "_bvalid"}, {31'd0, wr_valid}, 32'd1);
        check({tag, "_bresp"}, {31'd0, wr_breap}, {31'd0, ok});
        step();
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                            input logic ok);
        bit done = 1'b0;
        int unsigned n = 0;
        ar_valid = 1'b1; ar_addr = addr;
        rd_ready = 1'b1;
        while (!done && n < 20) begin
            @(negedge aclk);
            if (ar_valid && ar_ready) done = 1'b1;
            step();
            if (done) ar_valid = 1'b0;
            n++;
        end
        ar_valid = 1'b0;
        check({tag, "_hs"}, {31'd0, done}, 32'd1);
        @(negedge aclk);
        check({tag, "_ce"}, {31'd0, sram_ce}, {31'd0, ok});
        check({tag, "_we"}, {31'd0, sram_we}, 32'd0);
        check({tag, "_early"}, {31'd0, rd_valid}, 32'd0);
        step();
        @(negedge aclk);
        check({tag, "_rvalid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_rdata"}, rd_data, exp);
        check({tag, "_rresp"}, {31'd0, rd_resp}, {31'd0, ok});
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; ar_prot = '0;
        aw_valid = 1'b0; aw_addr = '0; aw_prot = '0;
        wd_valid = 1'b0; wd_data = '0; wstrb = '0;
        rd_ready = 1'b1; wr_ready = 1'b1;
        step();
        @(negedge aclk);
        check("rst_ar_ready", {31'd0, ar_ready}, 32'd0);
        check("rst_aw_ready", {31'd0, aw_ready}, 32'd0);
        check("rst_wd_ready", {31'd0, wd_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_sram_ce", {31'd0, sram_ce}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        step();
        reset = 1'b0;

        axi_write("wr10", 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
        axi_read("rd10", 32'h10, 32'hDEAD_BEEF, 1'b1);

        axi_write("wr20", 32'h20, 32'h1122_3344, 4'hF, 1'b1);
        axi_write("wr20b", 32'h20, 32'h0000_00AA, 4'h1, 1'b1);
        axi_read("rd20", 32'h20, 32'h1122_33AA, 1'b1);

        // AW in cycle 0, W in cycle 3
        aw_valid = 1'b1; aw_addr = 32'h30;
        @(negedge aclk);
        check("split_aw_ready", {31'd0, aw_ready}, 32'd1);
        step();
        aw_valid = 1'b0;
        @(negedge aclk);
        check("split_aw_held", {31'd0, aw_ready}, 32'd0);
        check("split_ar_blocked", {31'd0, ar_ready}, 32'd0);
        check("split_c1_ce", {31'd0, sram_ce}, 32'd0);
        step();
        @(negedge aclk);
        check("split_c2_wvalid", {31'd0, wr_valid}, 32'd0);
        step();
        wd_valid = 1'b1; wd_data = 32'h55AA_55AA; wstrb = 4'hF;
        @(negedge aclk);
        check("split_wd_ready", {31'd0, wd_ready}, 32'd1);
        step();
        wd_valid = 1'b0;
        @(negedge aclk);
        check("split_c4_cewe", {30'd0, sram_ce, sram_we}, 32'd3);
        check("split_c4_addr", {22'd0, sram_addr}, 32'd12);
        check("split_c4_wdata", sram_wdata, 32'h55AA_55AA);
        check("split_c4_wvalid", {31'd0, wr_valid}, 32'd0);
        step();
        @(negedge aclk);
        check("split_c5_wvalid", {31'd0, wr_valid}, 32'd1);
        check("split_c5_bresp", {31'd0, wr_breap}, 32'd1);
        step();
        axi_read("rd30", 32'h30, 32'h55AA_55AA, 1'b1);

        axi_write("wstrb0", 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1);
        axi_read("rd10_after0", 32'h10, 32'hDEAD_BEEF, 1'b1);

        axi_write("wr0", 32'h0, 32'h0BAD_CAFE, 4'hF, 1'b1);
        axi_read("rd_oor", 32'h1000, 32'h0, 1'b0);
        axi_write("wr_oor", 32'h1000, 32'h1234_5678, 4'hF, 1'b0);
        axi_read("rd0_after_oor", 32'h0, 32'h0BAD_CAFE, 1'b1);

        // Contention right after reset: read first, then the held write
        reset = 1'b1;
        step();
        reset = 1'b0;
        ar_valid = 1'b1; ar_addr = 32'h10;
        aw_valid = 1'b1; aw_addr = 32'h40;
        wd_valid = 1'b1; wd_data = 32'hCAFE_F00D; wstrb = 4'hF;
        @(negedge aclk);
        check("arb1_ar_ready", {31'd0, ar_ready}, 32'd1);
        check("arb1_aw_wd_ready", {30'd0, aw_ready, wd_ready}, 32'd3);
        step();
        aw_valid = 1'b0; wd_valid = 1'b0; ar_addr = 32'h40;
        @(negedge aclk);
        check("arb1_rd_ce", {30'd0, sram_ce, sram_we}, 32'd2);
        check("arb1_rd_addr", {22'd0, sram_addr}, 32'd4);
        step();
        @(negedge aclk);
        check("arb1_rdata", rd_data, 32'hDEAD_BEEF);
        step();
        @(negedge aclk);
        check("arb2_ar_blocked", {31'd0, ar_ready}, 32'd0);
        step();
        @(negedge aclk);
        check("arb2_wr_cewe", {30'd0, sram_ce, sram_we}, 32'd3);
        check("arb2_wr_addr", {22'd0, sram_addr}, 32'd16);
        step();
        @(negedge aclk);
        check("arb2_bvalid", {31'd0, wr_valid}, 32'd1);
        step();
        @(negedge aclk);
        check("arb3_ar_ready", {31'd0, ar_ready}, 32'd1);
        step();
        ar_valid = 1'b0;
        step();
        @(negedge aclk);
        check("arb3_rdata", rd_data, 32'hCAFE_F00D);
        step();

        // Read response back-pressure, then reset during RD_RESP
        rd_ready = 1'b0;
        ar_valid = 1'b1; ar_addr = 32'h20;
        @(negedge aclk);
        check("stall_ar_ready", {31'd0, ar_ready}, 32'd1);
        step();
        ar_valid = 1'b0;
        step();
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge aclk);
            check($sformatf("stall_rvalid_%0d", i), {31'd0, rd_valid}, 32'd1);
            check($sformatf("stall_rdata_%0d", i), rd_data, 32'h1122_33AA);
            step();
        end
        reset = 1'b1;
        @(negedge aclk);
        check("rst_in_resp_rvalid", {31'd0, rd_valid}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge aclk);
        check("post_rst_rvalid", {31'd0, rd_valid}, 32'd0);
        check("post_rst_idle", {31'd0, ar_ready}, 32'd1);
        rd_ready = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
